// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: opcode/ready in, datapath controls, state code,
// illegal pulse and retired-instruction count out.
interface mc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       Op;
  logic             MemRdy;
  logic             PCWr;
  logic             PCWrCond;
  logic             PCWrCondN;
  logic             IorD;
  logic             MemRd;
  logic             MemWr;
  logic             IRWr;
  logic             MemtoReg;
  logic             ALUSrcA;
  logic             RegWr;
  logic             RegDst;
  logic [1:0]       PCSrc;
  logic [1:0]       ALUOp;
  logic [1:0]       ALUSrcB;
  logic [3:0]       S;
  logic             Illegal;
  logic [CNT_W-1:0] InstCnt;

  modport master (
    input  Op, MemRdy,
    output PCWr, PCWrCond, PCWrCondN, IorD, MemRd, MemWr, IRWr, MemtoReg,
           ALUSrcA, RegWr, RegDst, PCSrc, ALUOp, ALUSrcB, S, Illegal, InstCnt
  );

  modport slave (
    output Op, MemRdy,
    input  PCWr, PCWrCond, PCWrCondN, IorD, MemRd, MemWr, IRWr, MemtoReg,
           ALUSrcA, RegWr, RegDst, PCSrc, ALUOp, ALUSrcB, S, Illegal, InstCnt
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-style control FSM: Moore outputs per state (IRWr/PCWr follow MemRdy in FETCH).
// FETCH/MEMRD/MEMWR stall while MemRdy is low when MEM_HS=1; all other states take one cycle.
module mc_ctrl #(
  parameter bit MEM_HS  = 1'b1,
  parameter bit EXT_ISA = 1'b1,
  parameter int CNT_W   = 32
) (
  input  logic         CLK,
  input  logic         Rst,
  mc_ctrl_if.master    bus
);

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_RWB    = 4'd7,
    ST_BEQ    = 4'd8,
    ST_JUMP   = 4'd9,
    ST_ADDIEX = 4'd10,
    ST_ADDIWB = 4'd11,
    ST_BNE    = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] inst_cnt;
  logic             mem_rdy, retire, illegal;
  logic             pc_wr, pc_wr_cond, pc_wr_cond_n, ir_wr, reg_wr, mem_wr;
  logic             iord, mem_rd, mem_to_reg, alu_src_a, reg_dst;
  logic [1:0]       pc_src, alu_op, alu_src_b;

  assign mem_rdy = MEM_HS ? bus.MemRdy : 1'b1;

  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      state_q  <= ST_FETCH;
      inst_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (retire) inst_cnt <= inst_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d      = ST_FETCH;
    retire       = 1'b0;
    illegal      = 1'b0;
    pc_wr        = 1'b0;
    pc_wr_cond   = 1'b0;
    pc_wr_cond_n = 1'b0;
    ir_wr        = 1'b0;
    reg_wr       = 1'b0;
    mem_wr       = 1'b0;
    iord         = 1'b0;
    mem_rd       = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = 1'b0;
    reg_dst      = 1'b0;
    pc_src       = 2'b00;
    alu_op       = 2'b00;
    alu_src_b    = 2'b00;
    case (state_q)
      ST_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = 2'b01;
        ir_wr     = mem_rdy;
        pc_wr     = mem_rdy;
        state_d   = mem_rdy ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: begin
        alu_src_b = 2'b11;
        if (bus.Op == OP_R)                          state_d = ST_EXEC;
        else if (bus.Op == OP_LW || bus.Op == OP_SW) state_d = ST_MEMADR;
        else if (bus.Op == OP_BEQ)                   state_d = ST_BEQ;
        else if (EXT_ISA && bus.Op == OP_BNE)        state_d = ST_BNE;
        else if (EXT_ISA && bus.Op == OP_ADDI)       state_d = ST_ADDIEX;
        else if (EXT_ISA && bus.Op == OP_J)          state_d = ST_JUMP;
        else                                         illegal = 1'b1;
      end
      ST_MEMADR, ST_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (state_q == ST_ADDIEX) state_d = ST_ADDIWB;
        else                      state_d = (bus.Op == OP_LW) ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        mem_rd  = 1'b1;
        iord    = 1'b1;
        state_d = mem_rdy ? ST_MEMWB : ST_MEMRD;
      end
      ST_MEMWB: begin
        reg_wr     = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      ST_MEMWR: begin
        mem_wr  = 1'b1;
        iord    = 1'b1;
        retire  = mem_rdy;
        state_d = mem_rdy ? ST_FETCH : ST_MEMWR;
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = ST_RWB;
      end
      ST_RWB: begin
        reg_wr  = 1'b1;
        reg_dst = 1'b1;
        retire  = 1'b1;
      end
      ST_ADDIWB: begin
        reg_wr = 1'b1;
        retire = 1'b1;
      end
      ST_BEQ, ST_BNE: begin
        alu_src_a    = 1'b1;
        alu_op       = 2'b01;
        pc_src       = 2'b01;
        pc_wr_cond   = (state_q == ST_BEQ);
        pc_wr_cond_n = (state_q == ST_BNE);
        retire       = 1'b1;
      end
      ST_JUMP: begin
        pc_wr  = 1'b1;
        pc_src = 2'b10;
        retire = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Write enables are gated by reset so nothing commits while Rst is held low.
  assign bus.PCWr      = pc_wr & Rst;
  assign bus.PCWrCond  = pc_wr_cond & Rst;
  assign bus.PCWrCondN = pc_wr_cond_n & Rst;
  assign bus.IRWr      = ir_wr & Rst;
  assign bus.RegWr     = reg_wr & Rst;
  assign bus.MemWr     = mem_wr & Rst;
  assign bus.Illegal   = illegal & Rst;
  assign bus.IorD      = iord;
  assign bus.MemRd     = mem_rd;
  assign bus.MemtoReg  = mem_to_reg;
  assign bus.ALUSrcA   = alu_src_a;
  assign bus.RegDst    = reg_dst;
  assign bus.PCSrc     = pc_src;
  assign bus.ALUOp     = alu_op;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.S         = state_q;
  assign bus.InstCnt   = inst_cnt;

endmodule
